stage_memory: RTL and testbench

STAGE_MEMORY -- requirements
Module: stage_memory

---
 rtl/stage_memory.sv | 193 +++++++++++++++++++
 tb/tb_stage_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// Memory-access pipeline stage: captures execute results, runs one data-bus
// transaction per load/store with an ack timeout. Option: MEM_MISALIGN_TRAP_EN.
module stage_memory #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_to_reg,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_write_data,
   input  logic        ex_wr_enable,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [4:0]  mem_rd,
   output logic        mem_to_reg,
   output logic [31:0] mem_alu_result,
   output logic [31:0] mem_read_data,
   output logic        mem_wr_enable,
   output logic        mem_bus_err,
   output logic        mem_misaligned
);

   localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          cap_valid;
   logic [4:0]    cap_rd;
   logic          cap_to_reg;
   logic          cap_mem_write;
   logic [2:0]    cap_funct3;
   logic [31:0]   cap_alu;
   logic          cap_wr_en;

   logic          ex_is_load;
   logic          ex_is_store;
   logic          ex_misal;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [31:0]   ld_data;

   assign ex_is_store = ex_valid & ex_mem_write;
   assign ex_is_load  = ex_valid & ex_to_reg & ~ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      ex_misal = 1'b0;
      if (ex_is_load)
         ex_misal = ((ex_funct3 == 3'b001 || ex_funct3 == 3'b101) && ex_alu_result[0]) ||
                    (ex_funct3 == 3'b010 && ex_alu_result[1:0] != 2'b00);
      else if (ex_is_store)
         ex_misal = (ex_funct3 == 3'b001 && ex_alu_result[0]) ||
                    (ex_funct3 == 3'b010 && ex_alu_result[1:0] != 2'b00);
   end
`else
   assign ex_misal = 1'b0;
`endif

   always_comb begin
      st_be    = '0;
      st_wdata = '0;
      case (ex_funct3)
         3'b000: begin
            st_be    = 4'b0001 << ex_alu_result[1:0];
            st_wdata = {4{ex_write_data[7:0]}};
         end
         3'b001: begin
            st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ex_write_data[15:0]}};
         end
         3'b010: begin
            st_be    = 4'b1111;
            st_wdata = ex_write_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_b    = '0;
      ld_data = '0;
      case (cap_alu[1:0])
         2'd0:    ld_b = dmem_rdata[7:0];
         2'd1:    ld_b = dmem_rdata[15:8];
         2'd2:    ld_b = dmem_rdata[23:16];
         default: ld_b = dmem_rdata[31:24];
      endcase
      ld_h = cap_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (cap_funct3)
         3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
         3'b010:  ld_data = dmem_rdata;
         3'b100:  ld_data = {24'd0, ld_b};
         3'b101:  ld_data = {16'd0, ld_h};
         default: ld_data = '0;
      endcase
   end

   assign mem_stall      = (state == S_REQ);
   assign mem_rd         = cap_rd;
   assign mem_to_reg     = cap_to_reg;
   assign mem_alu_result = cap_alu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         cap_valid      <= 1'b0;
         cap_rd         <= '0;
         cap_to_reg     <= 1'b0;
         cap_mem_write  <= 1'b0;
         cap_funct3     <= '0;
         cap_alu        <= '0;
         cap_wr_en      <= 1'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_be        <= '0;
         mem_read_data  <= '0;
         mem_wr_enable  <= 1'b0;
         mem_bus_err    <= 1'b0;
         mem_misaligned <= 1'b0;
      end else begin
         // strobes are one-cycle unless re-asserted below
         mem_wr_enable  <= 1'b0;
         mem_bus_err    <= 1'b0;
         mem_misaligned <= 1'b0;
         case (state)
            S_REQ: begin
               if (dmem_ack) begin
                  state         <= S_DONE;
                  dmem_req      <= 1'b0;
                  dmem_we       <= 1'b0;
                  dmem_be       <= '0;
                  mem_read_data <= ld_data;
                  mem_wr_enable <= cap_valid & cap_to_reg & ~cap_mem_write & cap_wr_en;
               end else if (cnt == LAST) begin
                  state       <= S_DONE;
                  dmem_req    <= 1'b0;
                  dmem_we     <= 1'b0;
                  dmem_be     <= '0;
                  mem_bus_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cap_valid     <= ex_valid;
               cap_rd        <= ex_rd;
               cap_to_reg    <= ex_to_reg;
               cap_mem_write <= ex_mem_write;
               cap_funct3    <= ex_funct3;
               cap_alu       <= ex_alu_result;
               cap_wr_en     <= ex_wr_enable;
               if (ex_is_load || ex_is_store) begin
                  if (ex_misal) begin
                     state          <= S_DONE;
                     mem_misaligned <= 1'b1;
                  end else begin
                     state      <= S_REQ;
                     cnt        <= '0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= ex_is_store;
                     dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                     dmem_be    <= ex_is_store ? st_be : 4'b0000;
                     dmem_wdata <= ex_is_store ? st_wdata : 32'd0;
                  end
               end else begin
                  state         <= S_IDLE;
                  mem_wr_enable <= ex_valid & ex_wr_enable;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized self-checking bench for stage_memory against a transaction-level model.
module tb_stage_memory;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_to_reg, ex_mem_write, ex_wr_enable;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result, ex_write_data;
   logic        mem_stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [4:0]  mem_rd;
   logic        mem_to_reg, mem_wr_enable, mem_bus_err, mem_misaligned;
   logic [31:0] mem_alu_result, mem_read_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   stage_memory #(.ACK_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_to_reg(ex_to_reg),
      .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
      .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
      .ex_wr_enable(ex_wr_enable), .mem_stall(mem_stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .mem_rd(mem_rd), .mem_to_reg(mem_to_reg),
      .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
      .mem_wr_enable(mem_wr_enable), .mem_bus_err(mem_bus_err),
      .mem_misaligned(mem_misaligned)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic exp_misal(input logic st, input logic [2:0] f3, input logic [31:0] a);
      logic m;
      int unsigned off;
      logic half, word;
      off  = a % 4;
      half = st ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
      word = (f3 == 3'd2);
      m = (half && (off % 2) != 0) || (word && off != 0);
`ifndef MEM_MISALIGN_TRAP_EN
      m = 1'b0;
`endif
      return m;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
      int unsigned bytes, off;
      logic [31:0] v;
      bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = (bytes == 4) ? 0 : ((a % 4) / bytes) * bytes;
      v     = w >> (8 * off);
      if (bytes < 4) begin
         v = v % (32'd1 << (8 * bytes));
         if (!f3[2] && v >= (32'd1 << (8 * bytes - 1)))
            v = v + (32'hFFFF_FFFF << (8 * bytes));
      end
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) v = 32'd0;
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0:    return 4'b0001 << (a % 4);
         3'd1:    return 4'b0011 << (((a % 4) / 2) * 2);
         3'd2:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return {24'd0, d[7:0]} * 32'h0101_0101;
         3'd1:    return {16'd0, d[15:0]} * 32'h0001_0001;
         3'd2:    return d;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk_reset(input string tag);
      check({tag, "_ctl"}, {dmem_req, dmem_we, dmem_be, mem_stall, mem_wr_enable, mem_rd,
                           mem_to_reg, mem_bus_err, mem_misaligned}, 32'd0);
      check({tag, "_addr"}, dmem_addr, 32'd0);
      check({tag, "_wdata"}, dmem_wdata, 32'd0);
      check({tag, "_alu"}, mem_alu_result, 32'd0);
      check({tag, "_rdata"}, mem_read_data, 32'd0);
   endtask

   // non-memory instruction or bubble; optional spurious ack must have no effect
   task automatic alu_op(input logic v, input logic we_en, input logic [4:0] rd,
                         input logic [31:0] res, input logic spur);
      ex_valid = v; ex_rd = rd; ex_to_reg = 1'b0; ex_mem_write = 1'b0;
      ex_funct3 = 3'($urandom_range(0, 7)); ex_alu_result = res;
      ex_write_data = $urandom; ex_wr_enable = we_en; dmem_ack = spur;
      @(posedge clk); #1;
      dmem_ack = 1'b0; ex_valid = 1'b0;
      check("alu_wb", mem_wr_enable, v & we_en);
      check("alu_stall", mem_stall, 0);
      check("alu_req", dmem_req, 0);
      if (v) begin
         check("alu_rd", mem_rd, rd);
         check("alu_res", mem_alu_result, res);
      end
   endtask

   task automatic mem_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input logic we_en,
                         input int ack_at, input logic [4:0] rd);
      logic mis, to;
      int   cnt;
      mis = exp_misal(st, f3, a);
      to  = (ack_at == 0);
      ex_valid = 1'b1; ex_rd = rd; ex_to_reg = !st; ex_mem_write = st; ex_funct3 = f3;
      ex_alu_result = a; ex_write_data = wd; ex_wr_enable = we_en;
      dmem_rdata = rdat; dmem_ack = 1'b0;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      if (mis) begin
         check("mis_stall", mem_stall, 0);
         check("mis_req", dmem_req, 0);
         check("mis_flag", mem_misaligned, 1);
         check("mis_wb", mem_wr_enable, 0);
      end else begin
         check("req_stall", mem_stall, 1);
         check("req_req", dmem_req, 1);
         check("req_we", dmem_we, st);
         check("req_addr", dmem_addr, {a[31:2], 2'b00});
         if (st) begin
            check("req_be", dmem_be, exp_be(f3, a));
            check("req_wdata", dmem_wdata, exp_wd(f3, wd));
         end
         cnt = 1;
         for (int i = 1; i <= T + 2; i++) begin
            dmem_ack = (i == ack_at);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!mem_stall) break;
            cnt++;
            check("req_hold", dmem_req, 1);
         end
         check("req_cycles", cnt, to ? T : ack_at);
         check("done_err", mem_bus_err, to);
         check("done_wb", mem_wr_enable, !st && we_en && !to);
         check("done_req", dmem_req, 0);
         check("done_mis", mem_misaligned, 0);
         if (!st && !to) check("done_rdata", mem_read_data, exp_load(f3, a, rdat));
      end
      check("cap_rd", mem_rd, rd);
      check("cap_alu", mem_alu_result, a);
      check("cap_toreg", mem_to_reg, !st);
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_to_reg = 1'b0; ex_mem_write = 1'b0;
      ex_funct3 = '0; ex_alu_result = '0; ex_write_data = '0; ex_wr_enable = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      #12;
      chk_reset("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      alu_op(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0);
      mem_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1'b1, 3, 5'd7);
      mem_op(1'b1, 3'b001, 32'h202, 32'hABCD_1234, 32'h0, 1'b1, 1, 5'd9);
      mem_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h1111_2222, 1'b1, 0, 5'd3);
      alu_op(1'b1, 1'b1, 5'd6, 32'hCAFE, 1'b0);
      mem_op(1'b0, 3'b010, 32'h6, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 5'd4);
      alu_op(1'b1, 1'b0, 5'd8, 32'h55, 1'b1);

      // reset abandons an outstanding transaction; a later ack is ignored
      ex_valid = 1'b1; ex_rd = 5'd10; ex_to_reg = 1'b1; ex_mem_write = 1'b0;
      ex_funct3 = 3'b010; ex_alu_result = 32'h80; ex_wr_enable = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check("mid_stall", mem_stall, 1);
      rst_n = 1'b0; #1;
      chk_reset("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1; dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("post_stall", mem_stall, 0);
      check("post_wb", mem_wr_enable, 0);
      check("post_req", dmem_req, 0);
      check("post_rdata", mem_read_data, 32'd0);

      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(0, 3))
            0: alu_op(1'b1, 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
            1: alu_op(1'b0, 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
            2: mem_op(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      1'($urandom), $urandom_range(0, T), 5'($urandom));
            default: mem_op(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                            1'($urandom), $urandom_range(0, T), 5'($urandom));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
